// File: rtl/fb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_arb_pkg
// Description : Shared constants and types for the frame-buffer memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_arb_pkg;

    localparam int c_DW           = 24;
    localparam int c_AW           = 20;
    localparam int c_FRAME_PIXELS = 640 * 480;
    localparam int c_FIFO_DEPTH   = 16;

    typedef logic [c_DW-1:0] pixel_t;

    typedef struct packed {
        logic   sof;
        pixel_t pixel;
    } fifo_entry_t;

endpackage : fb_arb_pkg
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_wr_fifo
// Description : First-word-fall-through write FIFO with occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_wr_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW:0]    r_wptr;
    logic [c_PW:0]    r_rptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit separates the full case from the empty case.
    assign empty    = (r_wptr == r_rptr);
    assign full     = (r_wptr[c_PW] != r_rptr[c_PW]) &&
                      (r_wptr[c_PW-1:0] == r_rptr[c_PW-1:0]);
    assign w_pop    = pop && !empty;
    assign w_push   = push && (!full || w_pop);
    assign level    = r_wptr - r_rptr;
    assign pop_data = r_mem[r_rptr[c_PW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (c_PW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (c_PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_PW-1:0]] <= push_data;
    end

endmodule : fb_wr_fifo
`default_nettype wire

// File: rtl/fb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_mem_arbiter
// Description : Shares a single-port frame memory between display reads
//               (strict priority, 2-cycle latency) and buffered pixel writes.
//               FB_DOUBLE_BUFFER_EN selects two banks with swap at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_mem_arbiter
    import fb_arb_pkg::*;
#(
    parameter int DW           = c_DW,
    parameter int AW           = c_AW,
    parameter int FRAME_PIXELS = c_FRAME_PIXELS,
    parameter int FIFO_DEPTH   = c_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rd_frame_start,
    input  logic                          rd_req,
    output logic [DW-1:0]                 rd_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          wr_sof,
    input  logic [DW-1:0]                 wr_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    output logic [DW-1:0]                 mem_wdata,
    input  logic [DW-1:0]                 mem_rdata,
    output logic                          frame_swap,
    output logic                          wr_short_frame,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [AW-1:0] c_LAST_ADDR = AW'(FRAME_PIXELS - 1);

    logic [AW-1:0] r_rd_addr;
    logic [AW-1:0] r_wr_addr;
    logic          r_rd_pend;
    logic [DW-1:0] r_rd_data;
    logic          r_short_frame;

    logic [DW:0]   w_head;
    logic          w_head_sof;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic          w_wr_sel;
    logic          w_wr_stall;
    logic          w_frame_done;
    logic [AW-1:0] w_rd_addr_eff;
    logic [AW-1:0] w_wr_addr_eff;
    logic [AW-1:0] w_rd_base;
    logic [AW-1:0] w_wr_base;

    fb_wr_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (wr_valid && wr_ready),
        .push_data ({wr_sof, wr_data}),
        .pop       (w_wr_sel),
        .pop_data  (w_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .level     (fifo_level)
    );

    assign wr_ready       = !w_fifo_full;
    assign rd_data        = r_rd_data;
    assign wr_short_frame = r_short_frame;

    assign w_head_sof    = w_head[DW];
    assign w_wr_sel      = !rd_req && !w_fifo_empty && !w_wr_stall;
    assign w_rd_addr_eff = rd_frame_start ? '0 : r_rd_addr;
    assign w_wr_addr_eff = w_head_sof ? '0 : r_wr_addr;
    assign w_frame_done  = w_wr_sel && (w_wr_addr_eff == c_LAST_ADDR);

`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic [AW-1:0] c_BANK1_BASE = AW'(FRAME_PIXELS);

    logic r_rd_bank;
    logic r_pending_swap;
    logic r_frame_swap;
    logic w_swap;

    // A frame finishing in the same cycle as the VSync pulse still swaps.
    assign w_swap     = rd_frame_start && (r_pending_swap || w_frame_done);
    assign w_wr_stall = r_pending_swap;
    assign w_rd_base  = (r_rd_bank ^ w_swap) ? c_BANK1_BASE : '0;
    assign w_wr_base  = r_rd_bank ? '0 : c_BANK1_BASE;
    assign frame_swap = r_frame_swap;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_bank      <= 1'b0;
            r_pending_swap <= 1'b0;
            r_frame_swap   <= 1'b0;
        end else begin
            r_frame_swap <= w_swap;
            if (w_swap) begin
                r_rd_bank      <= ~r_rd_bank;
                r_pending_swap <= 1'b0;
            end else if (w_frame_done) begin
                r_pending_swap <= 1'b1;
            end
        end
    end
`else
    assign w_wr_stall = 1'b0;
    assign w_rd_base  = '0;
    assign w_wr_base  = '0;
    assign frame_swap = 1'b0;
`endif

    // Memory requests are suppressed while reset is asserted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rstn) begin
            if (rd_req) begin
                mem_en   = 1'b1;
                mem_addr = w_rd_base + w_rd_addr_eff;
            end else if (w_wr_sel) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_wr_base + w_wr_addr_eff;
                mem_wdata = w_head[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_addr     <= '0;
            r_wr_addr     <= '0;
            r_rd_pend     <= 1'b0;
            r_rd_data     <= '0;
            r_short_frame <= 1'b0;
        end else begin
            r_rd_pend <= rd_req;
            if (r_rd_pend) r_rd_data <= mem_rdata;

            if (rd_req)
                r_rd_addr <= (w_rd_addr_eff == c_LAST_ADDR) ? '0 : w_rd_addr_eff + AW'(1);
            else if (rd_frame_start)
                r_rd_addr <= '0;

            r_short_frame <= w_wr_sel && w_head_sof && (r_wr_addr != '0);
            if (w_wr_sel)
                r_wr_addr <= w_frame_done ? '0 : w_wr_addr_eff + AW'(1);
        end
    end

endmodule : fb_mem_arbiter
`default_nettype wire
